// File: rtl/ws2812_board_renderer_pkg.sv
// Shared colour constants, FSM encoding and helpers for the WS2812 board renderer.
package ws2812_board_renderer_pkg;

    localparam logic [23:0] WHITE      = 24'hFFFFFF;
    localparam logic [23:0] BLUE       = 24'h0000FF;
    localparam logic [23:0] LIGHT_BLUE = 24'hFF00FF;
    localparam logic [23:0] RED        = 24'h00FF00;
    localparam logic [23:0] LIGHT_RED  = 24'h3CFF00;
    localparam logic [23:0] NONE       = 24'h000000;

    localparam int BITS_PER_LED = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_LATCH
    } state_t;

    function automatic int ns_to_cycles(input int ns, input int mhz);
        return ns * mhz / 1000;
    endfunction

    // GRB colour of one square; the cursor overrides everything, player beats cpu.
    function automatic logic [23:0] square_colour(input logic player, input logic cpu,
                                                  input logic king, input logic hit,
                                                  input logic [1:0] dim);
        logic [23:0] c;
        if (hit)         c = WHITE;
        else if (player) c = king ? LIGHT_BLUE : BLUE;
        else if (cpu)    c = king ? LIGHT_RED : RED;
        else             c = NONE;
        return {c[23:16] >> dim, c[15:8] >> dim, c[7:0] >> dim};
    endfunction

endpackage

// File: rtl/ws2812_board_renderer_if.sv
// Game-state and frame handshake bundle between the game logic and the renderer.
interface ws2812_board_renderer_if #(
    parameter int NUM_SQUARES = 32
);
    logic [NUM_SQUARES-1:0]         player_pieces;
    logic [NUM_SQUARES-1:0]         cpu_pieces;
    logic [NUM_SQUARES-1:0]         king_pieces;
    logic                           cursor_en;
    logic [$clog2(NUM_SQUARES)-1:0] cursor_sq;
    logic [1:0]                     dim;
    logic                           auto_refresh;
    logic                           start;
    logic                           busy;
    logic                           frame_done;

    modport master (
        output player_pieces, cpu_pieces, king_pieces, cursor_en, cursor_sq,
               dim, auto_refresh, start,
        input  busy, frame_done
    );

    modport slave (
        input  player_pieces, cpu_pieces, king_pieces, cursor_en, cursor_sq,
               dim, auto_refresh, start,
        output busy, frame_done
    );
endinterface

// File: rtl/ws2812_board_renderer_bit_tx.sv
// Single-bit WS2812 waveform generator: high for T0H/T1H, low to the bit period.
module ws2812_board_renderer_bit_tx #(
    parameter int T0H  = 40,
    parameter int T1H  = 80,
    parameter int TBIT = 125
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_i,
    input  logic valid_i,
    output logic ready_o,
    output logic dout_o
);
    localparam int CW = $clog2(TBIT);

    logic [CW-1:0] cnt_q;
    logic          active_q;
    logic          bit_q;
    logic          dout_q;

    // A new bit accepted on the ready cycle starts with no gap.
    assign ready_o = active_q && (cnt_q == CW'(TBIT - 1));
    assign dout_o  = dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            if (valid_i) begin
                active_q <= 1'b1;
                bit_q    <= bit_i;
                cnt_q    <= '0;
            end else if (ready_o) begin
                active_q <= 1'b0;
            end else if (active_q) begin
                cnt_q <= cnt_q + CW'(1);
            end
            dout_q <= active_q && (cnt_q < CW'(bit_q ? T1H : T0H));
        end
    end
endmodule

// File: rtl/ws2812_board_renderer.sv
// WS2812 checkers-board renderer: snapshots the board, maps squares to GRB and
// streams the frame followed by the latch gap.
module ws2812_board_renderer
    import ws2812_board_renderer_pkg::*;
#(
    parameter int NUM_SQUARES     = 32,
    parameter int LEDS_PER_SQUARE = 2,
    parameter int SYS_FREQ_MHZ    = 100,
    parameter int T0H_NS          = 400,
    parameter int T1H_NS          = 800,
    parameter int BIT_PERIOD_NS   = 1250,
    parameter int LATCH_US        = 60
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ws2812_board_renderer_if.slave  bus,
    output logic                    led_dout_o
);
    localparam int T0H    = ns_to_cycles(T0H_NS, SYS_FREQ_MHZ);
    localparam int T1H    = ns_to_cycles(T1H_NS, SYS_FREQ_MHZ);
    localparam int TBIT   = ns_to_cycles(BIT_PERIOD_NS, SYS_FREQ_MHZ);
    localparam int TLATCH = LATCH_US * SYS_FREQ_MHZ;
    localparam int SQW    = $clog2(NUM_SQUARES);
    localparam int SUBW   = (LEDS_PER_SQUARE > 1) ? $clog2(LEDS_PER_SQUARE) : 1;
    localparam int LW     = $clog2(TLATCH);

    state_t          state_q;
    logic            busy_q, done_q, boot_q, first_q, issued_q;
    logic [SQW-1:0]  sq_q;
    logic [SUBW-1:0] sub_q;
    logic [4:0]      bit_q;
    logic [LW-1:0]   lat_q;
    logic [23:0]     colour_d [NUM_SQUARES];
    logic [23:0]     colour_q [NUM_SQUARES];
    logic            tx_valid, tx_ready, tx_bit, led_lit, last_bit;

    for (genvar gi = 0; gi < NUM_SQUARES; gi++) begin : g_square
        assign colour_d[gi] = square_colour(bus.player_pieces[gi], bus.cpu_pieces[gi],
                                            bus.king_pieces[gi],
                                            bus.cursor_en && (bus.cursor_sq == SQW'(gi)),
                                            bus.dim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SQUARES; i++) colour_q[i] <= '0;
        end else if (state_q == ST_LOAD) begin
            for (int i = 0; i < NUM_SQUARES; i++) colour_q[i] <= colour_d[i];
        end
    end

    assign led_lit  = (sub_q == SUBW'(LEDS_PER_SQUARE - 1));
    assign tx_bit   = led_lit & colour_q[sq_q][5'd23 - bit_q];
    assign last_bit = (bit_q == 5'(BITS_PER_LED - 1)) && led_lit &&
                      (sq_q == SQW'(NUM_SQUARES - 1));
    assign tx_valid = (state_q == ST_SEND) && !issued_q && (first_q || tx_ready);

    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

    // Leaving reset in LATCH (with boot_q) guarantees a full low gap before the
    // first frame, without reporting busy or frame_done for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LATCH;
            boot_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            first_q  <= 1'b0;
            issued_q <= 1'b0;
            sq_q     <= '0;
            sub_q    <= '0;
            bit_q    <= '0;
            lat_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q  <= ST_SEND;
                    first_q  <= 1'b1;
                    issued_q <= 1'b0;
                    sq_q     <= '0;
                    sub_q    <= '0;
                    bit_q    <= '0;
                end
                ST_SEND: begin
                    if (tx_valid) begin
                        first_q <= 1'b0;
                        if (last_bit) begin
                            issued_q <= 1'b1;
                        end else if (bit_q == 5'(BITS_PER_LED - 1)) begin
                            bit_q <= '0;
                            if (led_lit) begin
                                sub_q <= '0;
                                sq_q  <= sq_q + SQW'(1);
                            end else begin
                                sub_q <= sub_q + SUBW'(1);
                            end
                        end else begin
                            bit_q <= bit_q + 5'd1;
                        end
                    end
                    if (tx_ready && issued_q) begin
                        state_q <= ST_LATCH;
                        lat_q   <= '0;
                    end
                end
                ST_LATCH: begin
                    lat_q <= lat_q + LW'(1);
                    if (lat_q == LW'(TLATCH - 2) && !boot_q) done_q <= 1'b1;
                    if (lat_q == LW'(TLATCH - 1)) begin
                        lat_q  <= '0;
                        boot_q <= 1'b0;
                        if (bus.auto_refresh && !boot_q) begin
                            state_q <= ST_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ws2812_board_renderer_bit_tx #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_i   (tx_bit),
        .valid_i (tx_valid),
        .ready_o (tx_ready),
        .dout_o  (led_dout_o)
    );
endmodule

// File: tb/tb_ws2812_board_renderer.sv
// Directed bench for the board renderer using a small, fast-timing build
// (6 squares x 2 LEDs, 3/7/10-cycle bits, 100-cycle latch).
module tb_ws2812_board_renderer;
    localparam int NSQ   = 6;
    localparam int NLED  = NSQ * 2;
    localparam int TL    = 100;
    localparam int FRAME = NLED * 24 * 10 + TL + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic led_dout;

    always #5 clk = ~clk;

    ws2812_board_renderer_if #(.NUM_SQUARES(NSQ)) bus ();

    ws2812_board_renderer #(
        .NUM_SQUARES     (NSQ),
        .LEDS_PER_SQUARE (2),
        .SYS_FREQ_MHZ    (100),
        .T0H_NS          (30),
        .T1H_NS          (70),
        .BIT_PERIOD_NS   (100),
        .LATCH_US        (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .led_dout_o (led_dout)
    );

    int          checks = 0;
    int          errors = 0;
    int          timing_err;
    logic [23:0] leds   [NLED];
    logic [23:0] exp_sq [NSQ];

    int   cyc = 0, done_cnt = 0, busy_rise_cyc = 0, busy_len = 0;
    logic busy_prev = 1'b0;
    int   done_times [$];

    always @(negedge clk) begin
        cyc++;
        if (bus.frame_done) begin
            done_cnt++;
            done_times.push_back(cyc);
        end
        if (bus.busy && !busy_prev) busy_rise_cyc = cyc;
        if (!bus.busy && busy_prev) busy_len = cyc - busy_rise_cyc;
        busy_prev = bus.busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_exp(input logic [23:0] c0, c1, c2, c3, c4, c5);
        exp_sq[0] = c0; exp_sq[1] = c1; exp_sq[2] = c2;
        exp_sq[3] = c3; exp_sq[4] = c4; exp_sq[5] = c5;
    endtask

    // Decode one frame from pulse widths; the final bit's low phase runs into the latch.
    task automatic capture_frame(input string tag);
        int t, h, l;
        timing_err = 0;
        t = 0;
        while (!led_dout && t < 200) begin @(negedge clk); t++; end
        check({tag, "_first_high"}, led_dout, 1);
        for (int k = 0; k < NLED; k++) begin
            for (int b = 23; b >= 0; b--) begin
                h = 0;
                while (led_dout && h < 20) begin @(negedge clk); h++; end
                l = 0;
                while (!led_dout && l < 20) begin @(negedge clk); l++; end
                leds[k][b] = (h > 5);
                if (!(h == 3 || h == 7)) timing_err++;
                if (!(k == NLED - 1 && b == 0) && (h + l != 10)) timing_err++;
            end
        end
    endtask

    task automatic wait_busy_low(input string tag, input int limit);
        int t = 0;
        while (bus.busy && t < limit) begin @(negedge clk); t++; end
        check({tag, "_busy_timeout"}, bus.busy, 0);
    endtask

    task automatic run_frame(input string tag, input bit hold_start, input bit mutate);
        int d0 = done_cnt;
        @(negedge clk);
        check({tag, "_idle"}, bus.busy, 0);
        bus.start = 1'b1;
        @(negedge clk);
        check({tag, "_busy_rise"}, bus.busy, 1);
        if (!hold_start) bus.start = 1'b0;
        @(negedge clk);
        if (mutate) begin
            bus.player_pieces = '1;
            bus.king_pieces   = '1;
            bus.cursor_en     = 1'b1;
            bus.cursor_sq     = 3'd0;
            bus.dim           = 2'd3;
        end
        capture_frame(tag);
        bus.start = 1'b0;
        wait_busy_low(tag, 500);
        repeat (50) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_still_idle"}, bus.busy, 0);
        check({tag, "_busy_len"}, busy_len, FRAME);
        check({tag, "_bit_timing"}, timing_err, 0);
        for (int k = 0; k < NLED; k++)
            check($sformatf("%s_led%0d", tag, k), leds[k], (k % 2 == 1) ? exp_sq[k / 2] : 24'h0);
        $display("frame %s: busy_len=%0d done_pulses=%0d timing_err=%0d",
                 tag, busy_len, done_cnt - d0, timing_err);
    endtask

    initial begin
        int t;
        bus.player_pieces = '0;
        bus.cpu_pieces    = '0;
        bus.king_pieces   = '0;
        bus.cursor_en     = 1'b0;
        bus.cursor_sq     = '0;
        bus.dim           = 2'd0;
        bus.auto_refresh  = 1'b0;
        bus.start         = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.frame_done, 0);
        check("reset_dout", led_dout, 0);
        $display("reset: busy=%0b done=%0b dout=%0b", bus.busy, bus.frame_done, led_dout);

        // Start held from release: nothing may go high before a full latch gap.
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1;
        t = 0;
        while (!led_dout && t < 1000) begin @(negedge clk); t++; end
        check("boot_frame_high", led_dout, 1);
        check("boot_gap_ge_latch", (t >= TL), 1);
        $display("boot: first high after %0d cycles", t);

        rst_n = 1'b0;
        #1;
        check("midsend_rst_dout", led_dout, 0);
        check("midsend_rst_busy", bus.busy, 0);
        $display("mid-send reset: dout=%0b busy=%0b", led_dout, bus.busy);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);

        bus.player_pieces = 6'b000001;
        set_exp(24'h0000FF, 0, 0, 0, 0, 0);
        run_frame("single", 1'b0, 1'b0);

        bus.player_pieces = 6'b100100;
        bus.cpu_pieces    = 6'b110010;
        bus.king_pieces   = 6'b111100;
        set_exp(0, 24'h00FF00, 24'hFF00FF, 0, 24'h3CFF00, 24'hFF00FF);
        run_frame("priority", 1'b0, 1'b0);

        bus.cursor_en = 1'b1;
        bus.cursor_sq = 3'd5;
        bus.dim       = 2'd2;
        set_exp(0, 24'h003F00, 24'h3F003F, 0, 24'h0F3F00, 24'h3F3F3F);
        run_frame("cursor_dim2", 1'b0, 1'b0);

        bus.cursor_sq = 3'd7;
        bus.dim       = 2'd1;
        set_exp(0, 24'h007F00, 24'h7F007F, 0, 24'h1E7F00, 24'h7F007F);
        run_frame("cursor_oor", 1'b0, 1'b0);

        bus.player_pieces = 6'b000001;
        bus.cpu_pieces    = '0;
        bus.king_pieces   = '0;
        bus.cursor_en     = 1'b0;
        bus.dim           = 2'd0;
        set_exp(24'h0000FF, 0, 0, 0, 0, 0);
        run_frame("hold_mutate", 1'b1, 1'b1);

        // Auto-refresh: three back-to-back frames, cleared during the third.
        bus.player_pieces = '0;
        bus.king_pieces   = '0;
        bus.cursor_en     = 1'b0;
        bus.dim           = 2'd0;
        done_times.delete();
        bus.auto_refresh = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (done_times.size() < 2 && t < 3 * FRAME) begin @(negedge clk); t++; end
        repeat (500) @(negedge clk);
        bus.auto_refresh = 1'b0;
        t = 0;
        while (done_times.size() < 3 && t < 2 * FRAME) begin @(negedge clk); t++; end
        wait_busy_low("auto", 50);
        repeat (3) @(negedge clk);
        check("auto_pulses", done_times.size(), 3);
        if (done_times.size() >= 3) begin
            check("auto_period1", done_times[1] - done_times[0], FRAME);
            check("auto_period2", done_times[2] - done_times[1], FRAME);
        end
        check("auto_busy_held", busy_len, 3 * FRAME);
        check("auto_back_idle", bus.busy, 0);
        $display("auto-refresh: pulses=%0d busy_len=%0d", done_times.size(), busy_len);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
